// File: rtl/rs232_transmitter.sv
// RS-232 frame transmitter: start bit, 5..8 data bits LSB first, optional
// even/odd parity, one or two stop bits, optional CTS-gated frame start.
module rs232_transmitter #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int BYTE_LEN     = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 0,
    parameter int FLOW_CONTROL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_ready,
    input  logic       cts,
    output logic       tx_data_copied,
    output logic       tx_busy,
    output logic       tx
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [2:0] DATA_LAST = 3'(BYTE_LEN - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS);
    localparam logic [7:0] DATA_MASK = 8'((16'd1 << BYTE_LEN) - 16'd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Unused high data bits are masked off at load, so a full reduction is exact.
    function automatic logic calc_parity(input logic [7:0] data);
        logic p;
        p = ^data;
        return (PARITY == 2) ? ~p : p;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [TICK_W-1:0] tick_cnt_r, tick_nxt_s;
    logic [2:0]        bit_cnt_r, bit_nxt_s;
    logic [7:0]        data_r;
    logic              tx_r, busy_r, copied_r;
    logic              tx_nxt_s, busy_nxt_s, copied_nxt_s;
    logic              accept_s, bit_end_s, load_s;

    assign accept_s  = tx_data_ready & ((FLOW_CONTROL == 0) | cts);
    assign bit_end_s = (tick_cnt_r == TICK_LAST);

    // State, counters, latched byte and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TICK_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            data_r     <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            copied_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tick_cnt_r <= tick_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            data_r     <= load_s ? (tx_data & DATA_MASK) : data_r;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
            copied_r   <= copied_nxt_s;
        end
    end

    // Next-state, bit-timing and bit-index logic.
    always_comb begin
        state_nxt_s = state_r;
        bit_nxt_s   = bit_cnt_r;
        load_s      = 1'b0;
        if (state_r == ST_IDLE || bit_end_s) begin
            tick_nxt_s = {TICK_W{1'b0}};
        end else begin
            tick_nxt_s = tick_cnt_r + TICK_W'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                    bit_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && bit_cnt_r == DATA_LAST) begin
                    state_nxt_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    bit_nxt_s   = 3'd0;
                end else if (bit_end_s) begin
                    bit_nxt_s   = bit_cnt_r + 3'd1;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                    bit_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // A byte waiting at the end of the last stop bit starts a new frame with no idle gap.
                if (bit_end_s && bit_cnt_r == STOP_LAST) begin
                    bit_nxt_s = 3'd0;
                    if (accept_s) begin
                        state_nxt_s = ST_START;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (bit_end_s) begin
                    bit_nxt_s = bit_cnt_r + 3'd1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the state being entered.
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = data_r[bit_nxt_s];
            ST_PARITY: tx_nxt_s = calc_parity(data_r);
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        copied_nxt_s = load_s;
    end

    assign tx             = tx_r;
    assign tx_busy        = busy_r;
    assign tx_data_copied = copied_r;

endmodule
